// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the register-file write-back path.
//   DATA_W     register width
//   ADDR_W     register address width
//   REG_CNT    number of architectural registers
//   REG_R0     address of R0, which also has a dedicated write port
//   wb_entry_t one queued result: destination, main data, dual flag, R0 data
package cpu_pkg;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 4;
    localparam int REG_CNT = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] REG_R0 = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] data;
        logic              dual;
        logic [DATA_W-1:0] hi;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries (no fall-through, no bypass).
//   clk, rst      clock, synchronous active-low reset
//   clear         empties the FIFO at the next edge (overrides push/pop)
//   push/pushData write pushData at the tail; caller guarantees !full
//   pop/popData   popData is the current head; pop advances it; caller guarantees !empty
//   full/empty    occupancy flags
//   count         occupancy, 0..DEPTH
module wb_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  wb_entry_t        pushData,
    input  logic             pop,
    output wb_entry_t        popData,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; validity is tracked entirely by
    // the pointers and count, so clearing the data would only cost logic.
    always_ff @(posedge clk) begin
        if (rst && !clear && push) mem[wrPtr] <= pushData;
    end

    assign popData = mem[rdPtr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back sequencer for the register file.
// Buffers execute results in a FIFO, drives the main write port and the
// dedicated R0 port (for the high word of dual results), and tracks pending
// writes per register so decode can detect RAW hazards.
//   clk, rst                  clock, synchronous active-low reset
//   in_valid/in_ready         result handshake from execute
//   in_dst/in_data            main result and its destination
//   in_dual/in_data_hi        secondary result for R0
//   wb_hold                   stall draining
//   flush                     discard everything queued or in flight
//   wr_en/wr_addr/wr_data     main register-file write port (registered)
//   wr_r0_en/wr_r0_data       R0 write port (registered)
//   chk_addr_a/b, hazard_a/b  pending-write queries
//   err_collide               pulse with a dual write to R0 whose hi word was dropped
module regfile_wb_ctrl
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_dst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_dual,
    input  logic [DATA_W-1:0] in_data_hi,
    input  logic              wb_hold,
    input  logic              flush,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_r0_en,
    output logic [DATA_W-1:0] wr_r0_data,
    input  logic [ADDR_W-1:0] chk_addr_a,
    input  logic [ADDR_W-1:0] chk_addr_b,
    output logic              hazard_a,
    output logic              hazard_b,
    output logic              err_collide
);

    // Counter must hold every FIFO entry plus the write on the output port.
    localparam int PEND_W = $clog2(DEPTH + 2);
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic             push;
    logic             pop;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [CNT_W-1:0] fifoCount;
    wb_entry_t        pushEntry;
    wb_entry_t        headEntry;

    logic [PEND_W-1:0] pendCnt  [REG_CNT];
    logic [PEND_W-1:0] pendNext [REG_CNT];

    // in_ready ignores a same-cycle pop, so a full FIFO never accepts.
    assign in_ready  = !fifoFull && !flush;
    assign push      = in_valid && in_ready;
    assign pop       = !fifoEmpty && !wb_hold && !flush;
    assign pushEntry = '{dst: in_dst, data: in_data, dual: in_dual, hi: in_data_hi};

    wb_fifo #(.DEPTH(DEPTH)) uFifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .push     (push),
        .pushData (pushEntry),
        .pop      (pop),
        .popData  (headEntry),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    always_ff @(posedge clk) begin
        if (rst) assert (fifoCount <= CNT_W'(DEPTH));
    end

    // Output registers. addr/data hold when no write is issued.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_r0_en    <= 1'b0;
            wr_r0_data  <= '0;
            err_collide <= 1'b0;
        end else if (pop) begin
            wr_en       <= 1'b1;
            wr_addr     <= headEntry.dst;
            wr_data     <= headEntry.data;
            wr_r0_en    <= headEntry.dual && (headEntry.dst != REG_R0);
            wr_r0_data  <= headEntry.hi;
            err_collide <= headEntry.dual && (headEntry.dst == REG_R0);
        end else begin
            wr_en       <= 1'b0;
            wr_r0_en    <= 1'b0;
            err_collide <= 1'b0;
        end
    end

    // Scoreboard: net of this cycle's push (+1, +1 more on R0 for a split
    // dual) and the retire of whatever is on the write port now (-1 each).
    // NOTE: every element gets its current value first so no path through
    // this block leaves pendNext unassigned, which would infer a latch.
    always_comb begin
        for (int r = 0; r < REG_CNT; r++) begin
            pendNext[r] = pendCnt[r];
            if (push && in_dst == ADDR_W'(r))
                pendNext[r] = pendNext[r] + PEND_W'(1);
            if (push && r == 0 && in_dual && in_dst != REG_R0)
                pendNext[r] = pendNext[r] + PEND_W'(1);
            if (wr_en && wr_addr == ADDR_W'(r))
                pendNext[r] = pendNext[r] - PEND_W'(1);
            if (wr_r0_en && r == 0)
                pendNext[r] = pendNext[r] - PEND_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < REG_CNT; r++) begin
            if (!rst || flush) pendCnt[r] <= '0;
            else               pendCnt[r] <= pendNext[r];
        end
    end

    assign hazard_a = (pendCnt[chk_addr_a] != '0);
    assign hazard_b = (pendCnt[chk_addr_b] != '0);

endmodule
